// File: rtl/cpld_uart_responder_pkg.sv
// Shared types and helpers for the CPLD-style parallel UART responder.
// Imported by cpld_uart_responder and cpld_uart_rx.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Offset from the start-bit edge to the middle of the start bit.
    function automatic int half_bit(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/cpld_uart_responder_if.sv
// Parallel strobe/status bus between the memory/IO controller (master)
// and the UART responder (slave).
interface cpld_uart_responder_if;
    logic       uart_rdn;
    logic       uart_wrn;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;
    logic       uart_dataready;
    logic       uart_tbre;
    logic       uart_tsre;

    modport master (
        output uart_rdn, uart_wrn, data_in,
        input  data_out, data_oe, uart_dataready, uart_tbre, uart_tsre
    );

    modport slave (
        input  uart_rdn, uart_wrn, data_in,
        output data_out, data_oe, uart_dataready, uart_tbre, uart_tsre
    );
endinterface

// File: rtl/cpld_uart_rx.sv
// Serial receiver: 2-flop synchroniser plus 8N1 deserialiser, LSB first.
// Emits a one-cycle byte_valid pulse with rx_byte for each good frame.
module cpld_uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 line,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 byte_valid
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(half_bit(CLKS_PER_BIT) - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    logic                 sync1, sync2, sync3;
    rx_state_t            state;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           rx_bit;
    logic [DATA_BITS-1:0] shreg;
    logic                 ferr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            sync3      <= 1'b1;
            state      <= RX_IDLE;
            cnt        <= '0;
            rx_bit     <= '0;
            shreg      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            ferr       <= 1'b0;
        end else begin
            sync1      <= line;
            sync2      <= sync1;
            sync3      <= sync2;
            byte_valid <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (!sync2 && sync3) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        // Line back high at mid start bit: treat as a glitch.
                        if (sync2) begin
                            state <= RX_IDLE;
                        end else begin
                            state  <= RX_DATA;
                            rx_bit <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        shreg <= {sync2, shreg[DATA_BITS-1:1]};
                        if (rx_bit == LAST_BIT) begin
                            state <= RX_STOP;
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (ferr) begin
                        // Framing error: hold here until the line returns high.
                        if (sync2) begin
                            ferr  <= 1'b0;
                            state <= RX_IDLE;
                        end
                    end else if (cnt == FULL_M1) begin
                        cnt <= '0;
                        if (sync2) begin
                            rx_byte    <= shreg;
                            byte_valid <= 1'b1;
                            state      <= RX_IDLE;
                        end else begin
                            ferr <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/cpld_uart_responder.sv
// Device side of the CPLD-style parallel UART port: bus strobes, status flags,
// TX serialiser and RX buffer. Define UART_LOOPBACK_EN to feed txd back into RX.
module cpld_uart_responder
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                 clk,
    input  logic                 rst,
    cpld_uart_responder_if.slave bus,
    output logic                 txd,
    input  logic                 rxd
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    logic rdn_q, rdn_prev, wrn_q, wrn_prev;
    logic [7:0] data_out_reg, rx_buf, wr_data, tx_hold;
    logic data_oe_reg, dataready_reg, tbre_reg, tsre_reg, txd_reg;
    tx_state_t            tx_state;
    logic [CNT_W-1:0]     tx_cnt;
    logic [2:0]           tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 rx_line, rx_valid;
    logic [7:0]           rx_byte;

`ifdef UART_LOOPBACK_EN
    assign rx_line = txd_reg;
`else
    assign rx_line = rxd;
`endif

    cpld_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .line       (rx_line),
        .rx_byte    (rx_byte),
        .byte_valid (rx_valid)
    );

    // Read side and receive buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdn_q         <= 1'b1;
            rdn_prev      <= 1'b1;
            data_oe_reg   <= 1'b0;
            data_out_reg  <= '0;
            rx_buf        <= '0;
            dataready_reg <= 1'b0;
        end else begin
            rdn_q       <= bus.uart_rdn;
            rdn_prev    <= rdn_q;
            data_oe_reg <= ~rdn_q;
            if (!rdn_q) data_out_reg <= rx_buf;
            // A new byte wins over a read that starts in the same cycle.
            if (rx_valid) begin
                rx_buf        <= rx_byte;
                dataready_reg <= 1'b1;
            end else if (!rdn_q && rdn_prev) begin
                dataready_reg <= 1'b0;
            end
        end
    end

    // Write side and transmitter share tbre, so they live in one block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrn_q    <= 1'b1;
            wrn_prev <= 1'b1;
            wr_data  <= '0;
            tx_hold  <= '0;
            tbre_reg <= 1'b1;
            tsre_reg <= 1'b1;
            txd_reg  <= 1'b1;
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            wrn_q    <= bus.uart_wrn;
            wrn_prev <= wrn_q;
            if (!bus.uart_wrn) wr_data <= bus.data_in;
            if (wrn_q && !wrn_prev && tbre_reg) begin
                tx_hold  <= wr_data;
                tbre_reg <= 1'b0;
            end
            case (tx_state)
                TX_IDLE: begin
                    txd_reg <= 1'b1;
                    if (!tbre_reg) begin
                        tx_shift <= tx_hold;
                        tbre_reg <= 1'b1;
                        tsre_reg <= 1'b0;
                        txd_reg  <= 1'b0;
                        tx_cnt   <= '0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == FULL_M1) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        txd_reg  <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == FULL_M1) begin
                        tx_cnt <= '0;
                        if (tx_bit == LAST_BIT) begin
                            txd_reg  <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            txd_reg  <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == FULL_M1) begin
                        tx_cnt <= '0;
                        if (!tbre_reg) begin
                            tx_shift <= tx_hold;
                            tbre_reg <= 1'b1;
                            txd_reg  <= 1'b0;
                            tx_state <= TX_START;
                        end else begin
                            tsre_reg <= 1'b1;
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    assign bus.data_out       = data_out_reg;
    assign bus.data_oe        = data_oe_reg;
    assign bus.uart_dataready = dataready_reg;
    assign bus.uart_tbre      = tbre_reg;
    assign bus.uart_tsre      = tsre_reg;
    assign txd                = txd_reg;
endmodule

// File: tb/tb_cpld_uart_responder.sv
// Self-checking bench for cpld_uart_responder with CLKS_PER_BIT=4.
// TX frames are decoded by a monitor and checked against a scoreboard queue.
module tb_cpld_uart_responder;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic txd;
    logic rxd = 1'b1;

    cpld_uart_responder_if u_if ();

    cpld_uart_responder #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if),
        .txd (txd),
        .rxd (rxd)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int frame_cnt = 0;
    bit mon_en = 1'b1;
    logic [7:0] tx_q[$];
    int frame_starts[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // TX line monitor: decode each frame at bit centres and pop the scoreboard.
    initial begin
        logic [7:0] got;
        logic start_b, stop_b;
        int t0;
        forever begin
            @(negedge clk);
            if (mon_en && !rst && txd === 1'b0) begin
                t0 = cyc;
                repeat (CPB / 2) @(negedge clk);
                start_b = txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    got[i] = txd;
                end
                repeat (CPB) @(negedge clk);
                stop_b = txd;
                if (mon_en) begin
                    check("tx_start_bit", 32'(start_b), 32'd0);
                    check("tx_stop_bit", 32'(stop_b), 32'd1);
                    frame_starts.push_back(t0);
                    frame_cnt++;
                    if (tx_q.size() == 0) begin
                        vec_cnt++;
                        err_cnt++;
                        $display("FAIL tx_unexpected_frame: got %0h expected no frame", got);
                    end else begin
                        check("tx_frame", 32'(got), 32'(tx_q.pop_front()));
                    end
                end
            end
        end
    end

    task automatic write_byte(input logic [7:0] b, input bit accept);
        @(posedge clk); #1;
        u_if.uart_wrn = 1'b0;
        u_if.data_in  = b;
        repeat (2) @(posedge clk);
        #1;
        u_if.uart_wrn = 1'b1;
        u_if.data_in  = 8'h00;
        if (accept) tx_q.push_back(b);
    endtask

    task automatic read_check(input logic [7:0] exp);
        @(posedge clk); #1;
        u_if.uart_rdn = 1'b0;
        @(posedge clk); #1;
        check("rd_oe_early", 32'(u_if.data_oe), 32'd0);
        @(posedge clk); #1;
        check("rd_data", 32'(u_if.data_out), 32'(exp));
        check("rd_oe", 32'(u_if.data_oe), 32'd1);
        check("rd_dataready_clr", 32'(u_if.uart_dataready), 32'd0);
        u_if.uart_rdn = 1'b1;
        @(posedge clk); #1;
        check("rd_oe_hold", 32'(u_if.data_oe), 32'd1);
        @(posedge clk); #1;
        check("rd_oe_drop", 32'(u_if.data_oe), 32'd0);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        @(posedge clk); #1;
        rxd = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rxd = b[i];
            repeat (CPB) @(posedge clk);
        end
        #1 rxd = stop;
        repeat (CPB) @(posedge clk);
        #1 rxd = 1'b1;
    endtask

    task automatic wait_tsre(input int lim);
        int n;
        n = 0;
        while (u_if.uart_tsre !== 1'b1 && n < lim) begin
            @(posedge clk); #1;
            n++;
        end
        check("tsre_idle", 32'(u_if.uart_tsre), 32'd1);
        check("txd_idle", 32'(txd), 32'd1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_ready;
        logic [7:0] exp_buf;
    } rx_vec_t;

    rx_vec_t rx_tab[3];
    logic [7:0] tx_tab[4];

    initial begin
        int n;
        int nf;
        rx_tab[0] = '{data: 8'h3C, stop: 1'b1, exp_ready: 1'b1, exp_buf: 8'h3C};
        rx_tab[1] = '{data: 8'hFF, stop: 1'b0, exp_ready: 1'b0, exp_buf: 8'h3C};
        rx_tab[2] = '{data: 8'h81, stop: 1'b1, exp_ready: 1'b1, exp_buf: 8'h81};
        tx_tab[0] = 8'hA5;
        tx_tab[1] = 8'h00;
        tx_tab[2] = 8'hFF;
        tx_tab[3] = 8'h5A;

        u_if.uart_rdn = 1'b1;
        u_if.uart_wrn = 1'b1;
        u_if.data_in  = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_tbre", 32'(u_if.uart_tbre), 32'd1);
        check("rst_tsre", 32'(u_if.uart_tsre), 32'd1);
        check("rst_dataready", 32'(u_if.uart_dataready), 32'd0);
        check("rst_data_oe", 32'(u_if.data_oe), 32'd0);
        check("rst_data_out", 32'(u_if.data_out), 32'd0);

        // Single TX frames from idle, with exact holding-register timing.
        for (int i = 0; i < 4; i++) begin
            write_byte(tx_tab[i], 1'b1);
            @(posedge clk); #1;
            check("tx_tbre_before_commit", 32'(u_if.uart_tbre), 32'd1);
            @(posedge clk); #1;
            check("tx_tbre_commit", 32'(u_if.uart_tbre), 32'd0);
            @(posedge clk); #1;
            check("tx_tbre_load", 32'(u_if.uart_tbre), 32'd1);
            check("tx_tsre_busy", 32'(u_if.uart_tsre), 32'd0);
            check("tx_start_drive", 32'(txd), 32'd0);
            wait_tsre(200);
        end

        // Back-to-back frames, plus a write dropped while the holding register is full.
        nf = frame_cnt;
        write_byte(8'h55, 1'b1);
        n = 0;
        while (u_if.uart_tbre !== 1'b1 || u_if.uart_tsre !== 1'b0) begin
            @(posedge clk); #1;
            n++;
            if (n > 20) break;
        end
        write_byte(8'h0F, 1'b1);
        repeat (2) @(posedge clk);
        #1 check("b2b_tbre_full", 32'(u_if.uart_tbre), 32'd0);
        write_byte(8'hB6, 1'b0);
        wait_tsre(300);
        repeat (60) @(posedge clk);
        check("b2b_frame_count", 32'(frame_cnt - nf), 32'd2);
        if (frame_starts.size() >= 2)
            check("b2b_gap", 32'(frame_starts[$] - frame_starts[$-1]), 32'(10 * CPB));
        check("tx_queue_empty", 32'(tx_q.size()), 32'd0);

`ifdef UART_LOOPBACK_EN
        rxd = 1'b0;
        write_byte(8'hC3, 1'b1);
        n = 0;
        while (u_if.uart_dataready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("lb_dataready", 32'(u_if.uart_dataready), 32'd1);
        read_check(8'hC3);
        wait_tsre(200);
        rxd = 1'b1;
`else
        for (int i = 0; i < 3; i++) begin
            send_rx(rx_tab[i].data, rx_tab[i].stop);
            repeat (4) @(posedge clk);
            #1 check("rx_dataready", 32'(u_if.uart_dataready), 32'(rx_tab[i].exp_ready));
            read_check(rx_tab[i].exp_buf);
            repeat (8) @(posedge clk);
        end

        // One-cycle low glitch must not start a frame.
        @(posedge clk); #1 rxd = 1'b0;
        @(posedge clk); #1 rxd = 1'b1;
        repeat (60) @(posedge clk);
        #1 check("rx_glitch", 32'(u_if.uart_dataready), 32'd0);

        // Two unread frames: the newest byte wins.
        send_rx(8'h11, 1'b1);
        repeat (8) @(posedge clk);
        send_rx(8'h22, 1'b1);
        repeat (4) @(posedge clk);
        #1 check("rx_overwrite_ready", 32'(u_if.uart_dataready), 32'd1);
        read_check(8'h22);
        repeat (8) @(posedge clk);

        // Read strobe falls in the same cycle the byte completes.
        send_rx(8'h77, 1'b1);
        u_if.uart_rdn = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("rx_same_cycle_ready", 32'(u_if.uart_dataready), 32'd1);
        check("rx_same_cycle_data", 32'(u_if.data_out), 32'h77);
        u_if.uart_rdn = 1'b1;
        repeat (3) @(posedge clk);
        read_check(8'h77);

        // Read and write strobes low together.
        fork
            write_byte(8'h96, 1'b1);
            read_check(8'h77);
        join
        repeat (4) @(posedge clk);
        wait_tsre(200);
        repeat (10) @(posedge clk);
        check("rw_queue_empty", 32'(tx_q.size()), 32'd0);
`endif

        // Reset in the middle of a frame returns the line high at once.
        mon_en = 1'b0;
        write_byte(8'h00, 1'b0);
        repeat (15) @(posedge clk);
        #1 check("midrst_busy", 32'(u_if.uart_tsre), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("midrst_txd", 32'(txd), 32'd1);
        check("midrst_tsre", 32'(u_if.uart_tsre), 32'd1);
        check("midrst_tbre", 32'(u_if.uart_tbre), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
